// File: rtl/lane_sum_accumulator_pkg.sv
// Shared constants, types and the round/saturate helper for the lane-sum accumulator.
package lane_sum_accumulator_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 32;

  typedef logic [LANES-1:0][DATA_W_DEF-1:0] lane_arr_t;

  typedef enum logic {StIdle, StAccum} frame_st_e;

  // 64-bit working width keeps the rounding add from wrapping for any ACC_W up to 63.
  function automatic logic [63:0] round_sat(input logic [63:0] total,
                                            input int unsigned shift,
                                            input int unsigned data_w);
    logic [63:0] rounded;
    logic [63:0] max_val;
    rounded = (total + (64'd1 << (shift - 32'd1))) >> shift;
    max_val = (64'd1 << data_w) - 64'd1;
    return (rounded > max_val) ? max_val : rounded;
  endfunction

endpackage

// File: rtl/lane_sum_accumulator_add_pair_reg.sv
// Registered two-input adder with a valid bit; one node of the lane adder tree.
module add_pair_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W:0]   sum
);

  // Data is not reset; the cleared valid bit masks it downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
    if (in_valid) begin
      sum <= {1'b0, a} + {1'b0, b};
    end
  end

endmodule

// File: rtl/lane_sum_accumulator.sv
// 8-lane pipelined adder tree feeding a frame accumulator with a registered rounded-average result.
module lane_sum_accumulator
  import lane_sum_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BEATS  = 32,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [ACC_W-1:0]  acc,
  output logic [15:0]       beat_cnt,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_total,
  output logic [DATA_W-1:0] out_avg
);

  logic [DATA_W-1:0] lane [LANES];
  assign lane[0] = in0;
  assign lane[1] = in1;
  assign lane[2] = in2;
  assign lane[3] = in3;
  assign lane[4] = in4;
  assign lane[5] = in5;
  assign lane[6] = in6;
  assign lane[7] = in7;

  logic [DATA_W:0]   s1 [4];
  logic              v1 [4];
  logic [DATA_W+1:0] s2 [2];
  logic              v2 [2];
  logic [DATA_W+2:0] s3;
  logic              v3;

  for (genvar g = 0; g < 4; g++) begin : gen_s1
    add_pair_reg #(.W(DATA_W)) u_add (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (lane[2*g]),
      .b        (lane[2*g+1]),
      .out_valid(v1[g]),
      .sum      (s1[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : gen_s2
    add_pair_reg #(.W(DATA_W+1)) u_add (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v1[2*g] & v1[2*g+1]),
      .a        (s1[2*g]),
      .b        (s1[2*g+1]),
      .out_valid(v2[g]),
      .sum      (s2[g])
    );
  end

  add_pair_reg #(.W(DATA_W+2)) u_s3 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v2[0] & v2[1]),
    .a        (s2[0]),
    .b        (s2[1]),
    .out_valid(v3),
    .sum      (s3)
  );

  frame_st_e        frame_st;
  logic [ACC_W-1:0] base;
  logic [15:0]      base_cnt;
  logic [ACC_W-1:0] acc_next;
  logic [15:0]      cnt_next;

  // In StIdle acc still shows the previous frame's final value, so restart from zero.
  always_comb begin
    base     = (frame_st == StIdle) ? '0 : acc;
    base_cnt = (frame_st == StIdle) ? '0 : beat_cnt;
    acc_next = base + {{(ACC_W-DATA_W-3){1'b0}}, s3};
    cnt_next = base_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_st  <= StIdle;
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_avg   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (v3) begin
        acc      <= acc_next;
        beat_cnt <= cnt_next;
        if (cnt_next == 16'(BEATS)) begin
          out_valid <= 1'b1;
          out_total <= acc_next;
          out_avg   <= DATA_W'(round_sat(64'(acc_next), SHIFT, DATA_W));
          frame_st  <= StIdle;
        end else begin
          frame_st  <= StAccum;
        end
      end else if (frame_st == StIdle) begin
        acc      <= '0;
        beat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lane_sum_accumulator.sv
// Directed, table-driven bench for lane_sum_accumulator at default parameters.
module tb_lane_sum_accumulator;
  import lane_sum_accumulator_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in0, in1, in2, in3, in4, in5, in6, in7;
  logic [31:0] acc;
  logic [15:0] beat_cnt;
  logic        out_valid;
  logic [31:0] out_total;
  logic [7:0]  out_avg;

  lane_sum_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .in5      (in5),
    .in6      (in6),
    .in7      (in7),
    .acc      (acc),
    .beat_cnt (beat_cnt),
    .out_valid(out_valid),
    .out_total(out_total),
    .out_avg  (out_avg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] total;
    logic [7:0]  avg;
    logic [31:0] acc;
    logic [15:0] cnt;
  } pulse_t;

  typedef struct {
    int          cyc;
    logic [31:0] total;
    logic [7:0]  avg;
  } exp_t;

  typedef struct {
    lane_arr_t   first;
    lane_arr_t   rest;
    bit          gap;
    logic [31:0] total;
    logic [7:0]  avg;
  } vec_t;

  pulse_t pulses[$];
  exp_t   exps[$];
  vec_t   vecs[7];
  int     n_cmp  = 0;
  int     n_fail = 0;

  always @(negedge clk) begin
    if (out_valid === 1'b1) pulses.push_back('{cyc, out_total, out_avg, acc, beat_cnt});
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input lane_arr_t l, input bit v);
    in0 = l[0]; in1 = l[1]; in2 = l[2]; in3 = l[3];
    in4 = l[4]; in5 = l[5]; in6 = l[6]; in7 = l[7];
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, output int last);
    last = 0;
    for (int b = 0; b < 32; b++) begin
      drive((b == 0) ? v.first : v.rest, 1'b1);
      last = cyc;
      if (v.gap) drive('0, 1'b0);
    end
  endtask

  initial begin
    int        last;
    lane_arr_t ones;
    lane_arr_t fives;
    lane_arr_t ramp;
    lane_arr_t one127;
    lane_arr_t one128;

    ones   = {8{8'd1}};
    fives  = {8{8'd5}};
    ramp   = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    one127 = '0;
    one127[0] = 8'd127;
    one128 = '0;
    one128[0] = 8'd128;

    vecs[0] = '{{8{8'd255}}, {8{8'd255}}, 1'b0, 32'd65280, 8'd255};
    vecs[1] = '{ramp,        ramp,        1'b0, 32'd896,   8'd4};
    vecs[2] = '{one127,      '0,          1'b0, 32'd127,   8'd0};
    vecs[3] = '{one128,      '0,          1'b0, 32'd128,   8'd1};
    vecs[4] = '{ones,        ones,        1'b1, 32'd256,   8'd1};
    vecs[5] = '{{8{8'd2}},   {8{8'd2}},   1'b0, 32'd512,   8'd2};
    vecs[6] = '{{8{8'd3}},   {8{8'd3}},   1'b0, 32'd768,   8'd3};

    rst = 1'b1;
    repeat (3) drive('0, 1'b0);
    check("reset acc", acc, 0);
    check("reset beat_cnt", beat_cnt, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_total", out_total, 0);
    check("reset out_avg", out_avg, 0);
    rst = 1'b0;

    // Frames back to back; vecs 5 and 6 are contiguous so pulses land 32 cycles apart.
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], last);
      exps.push_back('{last + 3, vecs[i].total, vecs[i].avg});
    end
    repeat (6) drive('0, 1'b0);
    check("idle acc after frame", acc, 0);
    check("idle beat_cnt after frame", beat_cnt, 0);

    // Partial frame then bubbles: acc and beat_cnt must hold.
    repeat (3) drive(ones, 1'b1);
    repeat (5) drive('0, 1'b0);
    check("bubble hold acc", acc, 24);
    check("bubble hold beat_cnt", beat_cnt, 3);
    repeat (3) drive('0, 1'b0);
    check("bubble hold acc later", acc, 24);

    // Mid-stream reset with beats still in the tree.
    repeat (10) drive(fives, 1'b1);
    rst = 1'b1;
    drive(fives, 1'b1);
    check("midreset acc", acc, 0);
    check("midreset beat_cnt", beat_cnt, 0);
    check("midreset out_valid", out_valid, 0);
    check("midreset out_total", out_total, 0);
    check("midreset out_avg", out_avg, 0);
    rst = 1'b0;
    repeat (3) drive(ones, 1'b1);
    check("post-reset flushed acc", acc, 0);
    check("post-reset flushed beat_cnt", beat_cnt, 0);
    repeat (29) drive(ones, 1'b1);
    last = cyc;
    exps.push_back('{last + 3, 32'd256, 8'd1});
    repeat (8) drive('0, 1'b0);

    check("pulse count", pulses.size(), exps.size());
    for (int i = 0; i < exps.size() && i < pulses.size(); i++) begin
      check($sformatf("pulse%0d cycle", i), pulses[i].cyc, exps[i].cyc);
      check($sformatf("pulse%0d out_total", i), pulses[i].total, exps[i].total);
      check($sformatf("pulse%0d out_avg", i), pulses[i].avg, exps[i].avg);
      check($sformatf("pulse%0d acc", i), pulses[i].acc, exps[i].total);
      check($sformatf("pulse%0d beat_cnt", i), pulses[i].cnt, 32);
    end
    if (pulses.size() > 6) check("contiguous pulse spacing", pulses[6].cyc - pulses[5].cyc, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
